// File: rtl/uart_pixel_tx_pkg.sv
// Shared types and helpers for the POV display UART transmit path.
package pov_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int BYTES_PER_PIXEL = 3;

    // Integer-divided bit period in clock cycles.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Mirror a byte so bit 7 lands in bit 0.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_pixel_tx_if.sv
// Pixel word handshake between a pixel source and the UART pixel transmitter.
interface uart_pixel_tx_if;
    logic [23:0] pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (output pixel_in, output pixel_valid, input pixel_ready);
    modport slave  (input pixel_in, input pixel_valid, output pixel_ready);
endinterface

// File: rtl/uart_pixel_tx_byte.sv
// 8N1 byte serialiser. A byte offered on the last stop-bit cycle starts
// immediately on the next cycle, so consecutive bytes have no idle gap.
module uart_tx_byte
    import pov_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic       txd_o,
    output logic       done_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

    tx_state_e     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          txd_q;
    logic          done_q;

    // done_q is high exactly on the last stop-bit cycle, which is also the
    // only cycle outside IDLE where a new byte may be taken.
    assign byte_ready_o = (state_q == IDLE) || done_q;
    assign txd_o        = txd_q;
    assign done_o       = done_q;

    // Line state machine; TxD and done are registered so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (byte_valid_i) begin
                        sh_q    <= byte_i;
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= sh_q[1];
                            sh_q  <= {1'b0, sh_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_PRE) begin
                        done_q <= 1'b1;
                    end
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (byte_valid_i) begin
                            sh_q    <= byte_i;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_pixel_tx.sv
// Unpacks a 24-bit pixel into three wire bytes (b0, b1, b2) and sends them
// as back-to-back 8N1 frames through uart_tx_byte.
module uart_pixel_tx
    import pov_uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int REVERSE_BITS = 1
) (
    input  logic            clk,
    input  logic            RESET,
    uart_pixel_tx_if.slave  pix,
    output logic            TxD,
    output logic            busy,
    output logic            byte_done,
    output logic            pixel_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PIXEL - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_cpb_check
            $error("uart_pixel_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [23:0] shadow_q, shadow_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic        last_byte;
    logic [1:0]  next_idx;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_done;

    // Wire byte k of a pixel: order b0, b1, b2, optionally bit-mirrored.
    function automatic logic [7:0] wire_byte(input logic [23:0] px, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = px[15:8];
            2'd1:    b = px[7:0];
            default: b = px[23:16];
        endcase
        return (REVERSE_BITS != 0) ? bit_rev8(b) : b;
    endfunction

    assign accept    = pix.pixel_valid && ready_q;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign next_idx  = byte_idx_q + 2'd1;

    // The first byte comes straight from pixel_in so the start bit begins on
    // the acceptance edge; later bytes come from the shadow copy.
    assign tx_byte  = accept ? wire_byte(pix.pixel_in, 2'd0) : wire_byte(shadow_q, next_idx);
    assign tx_valid = accept || (tx_done && busy_q && !last_byte);

    assign pix.pixel_ready = ready_q;
    assign busy            = busy_q;
    assign byte_done       = tx_done;
    assign pixel_done      = tx_done && busy_q && last_byte;

    // Pixel sequencing: latch on accept, advance byte index on each byte end.
    always_comb begin
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        if (accept) begin
            shadow_d   = pix.pixel_in;
            byte_idx_d = 2'd0;
            busy_d     = 1'b1;
            ready_d    = 1'b0;
        end else if (pixel_done) begin
            byte_idx_d = 2'd0;
            busy_d     = 1'b0;
            ready_d    = 1'b1;
        end else if (tx_done && busy_q) begin
            byte_idx_d = next_idx;
        end else if (!busy_q) begin
            ready_d = 1'b1;
        end
    end

    // Pixel-level state registers.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            shadow_q   <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk         (clk),
        .rst         (RESET),
        .byte_i      (tx_byte),
        .byte_valid_i(tx_valid),
        .byte_ready_o(tx_ready),
        .txd_o       (TxD),
        .done_o      (tx_done)
    );

    // tx_ready mirrors pixel_ready/byte_done timing and is kept for the
    // standalone debug transmitter use of uart_tx_byte.
    logic unused_ready;
    assign unused_ready = tx_ready;

endmodule

// File: tb/tb_uart_pixel_tx.sv
// Scoreboard bench for uart_pixel_tx: two instances (reversed / plain bit
// order) share stimulus; a line decoder reconstructs bytes from TxD.
module tb_uart_pixel_tx;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] pix_in = '0;
    logic        pix_valid = 1'b0;

    uart_pixel_tx_if pif_r ();
    uart_pixel_tx_if pif_n ();
    assign pif_r.pixel_in    = pix_in;
    assign pif_r.pixel_valid = pix_valid;
    assign pif_n.pixel_in    = pix_in;
    assign pif_n.pixel_valid = pix_valid;

    logic [1:0] txd_a, busy_a, bd_a, pd_a, rdy_a;
    assign rdy_a = {pif_n.pixel_ready, pif_r.pixel_ready};

    uart_pixel_tx #(.CLK_HZ(1000), .BAUD(100), .REVERSE_BITS(1)) dut_r (
        .clk(clk), .RESET(RESET), .pix(pif_r.slave),
        .TxD(txd_a[0]), .busy(busy_a[0]), .byte_done(bd_a[0]), .pixel_done(pd_a[0])
    );
    uart_pixel_tx #(.CLK_HZ(1000), .BAUD(100), .REVERSE_BITS(0)) dut_n (
        .clk(clk), .RESET(RESET), .pix(pif_n.slave),
        .TxD(txd_a[1]), .busy(busy_a[1]), .byte_done(bd_a[1]), .pixel_done(pd_a[1])
    );

    typedef struct {
        logic [7:0] b;
        int         done;
        bit         last;
    } exp_t;

    exp_t       expq [2][$];
    logic [7:0] decq [2][$];
    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s inst%0d @cyc %0d: got 0x%0h expected 0x%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Reference: byte j of the pixel on the wire, instance 0 mirrors bits.
    function automatic logic [7:0] wire_ref(input logic [23:0] p, input int j, input int k);
        logic [7:0] b, r;
        b = (j == 0) ? p[15:8] : (j == 1) ? p[7:0] : p[23:16];
        r = {<<{b}};
        return (k == 0) ? r : b;
    endfunction

    // Monitor: decode TxD at mid-bit, pop expectations on each byte_done.
    bit         dact [2];
    int         dt   [2];
    logic [7:0] sh   [2];
    int         rdy_at [2];
    exp_t       e_m;
    logic [7:0] d_m;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                chk("reset_outputs", k, {txd_a[k], busy_a[k], bd_a[k], pd_a[k], rdy_a[k]}, 5'b10000);
                dact[k] = 1'b0;
                rdy_at[k] = 0;
                expq[k].delete();
                decq[k].delete();
            end else begin
                if (!dact[k]) begin
                    if (txd_a[k] == 1'b0) begin
                        dact[k] = 1'b1;
                        dt[k] = 0;
                    end
                end else begin
                    dt[k]++;
                end
                if (dact[k] && (dt[k] % CPB) == CPB / 2) begin
                    if (dt[k] / CPB == 0) begin
                        chk("start_bit", k, txd_a[k], 1'b0);
                    end else if (dt[k] / CPB <= 8) begin
                        sh[k][dt[k] / CPB - 1] = txd_a[k];
                    end else begin
                        chk("stop_bit", k, txd_a[k], 1'b1);
                        decq[k].push_back(sh[k]);
                        dact[k] = 1'b0;
                    end
                end
                if (rdy_at[k] != 0 && cyc == rdy_at[k]) begin
                    chk("ready_after_pixel", k, {rdy_a[k], busy_a[k]}, 2'b10);
                    rdy_at[k] = 0;
                end
                if (pd_a[k] && !bd_a[k]) chk("pixel_done_alone", k, bd_a[k], 1'b1);
                if (bd_a[k]) begin
                    if (expq[k].size() == 0) begin
                        chk("byte_done_expected", k, 0, 1);
                    end else begin
                        e_m = expq[k].pop_front();
                        d_m = (decq[k].size() != 0) ? decq[k].pop_front() : 8'hxx;
                        chk("decoded_byte", k, d_m, e_m.b);
                        chk("byte_done_cycle", k, cyc, e_m.done);
                        chk("pixel_done_flag", k, pd_a[k], e_m.last);
                        if (e_m.last) rdy_at[k] = cyc + 1;
                    end
                end
            end
        end
    end

    // Offer a pixel; junk pixel_in values are driven while the DUT is busy.
    task automatic send(input logic [23:0] px, input bit hold, output int n0);
        int w;
        exp_t e;
        n0 = -1;
        @(negedge clk);
        w = 0;
        while (rdy_a != 2'b11 && w < 400) begin
            pix_in = $urandom;
            pix_valid = 1'b1;
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 0, w < 400, 1);
        if (w >= 400) return;
        for (int k = 0; k < 2; k++) chk("pre_accept_idle", k, {txd_a[k], busy_a[k]}, 2'b10);
        pix_in = px;
        pix_valid = 1'b1;
        n0 = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                e.b = wire_ref(px, j, k);
                e.done = n0 + CPB * 10 * j + CPB * 10 - 1;
                e.last = (j == 2);
                expq[k].push_back(e);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("start_after_accept", k, {txd_a[k], busy_a[k], rdy_a[k]}, 3'b010);
        pix_in = $urandom;
        if (!hold) pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((expq[0].size() != 0 || expq[1].size() != 0 || rdy_a != 2'b11) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 0, w < 1000, 1);
    endtask

    initial begin
        int n0, prev, bad, w;
        logic [23:0] p;

        // Reset and idle
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 RESET = 1'b0;
        @(posedge clk);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd_a != 2'b11 || rdy_a != 2'b11 || busy_a != 2'b00) bad++;
        end
        chk("idle_100", 0, bad, 0);

        // Directed pixel, then a few random ones with random gaps
        send(24'h112233, 1'b0, n0);
        wait_idle();
        repeat (4) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send($urandom, 1'b0, n0);
            wait_idle();
        end

        // Valid held: 0x000000, 0xFFFFFF, then random; spacing must be 301
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            p = (i == 0) ? 24'h000000 : (i == 1) ? 24'hFFFFFF : 24'($urandom);
            send(p, i < 19, n0);
            if (i > 0) chk("pixel_spacing", 0, n0 - prev, 30 * CPB + 1);
            prev = n0;
        end
        wait_idle();

        // Reset during byte 1 data bit 4
        send(24'h112233, 1'b0, n0);
        w = 0;
        while (cyc < n0 + 153 && w < 400) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #2 RESET = 1'b1;
        #1;
        for (int k = 0; k < 2; k++)
            chk("reset_abort", k, {txd_a[k], busy_a[k], rdy_a[k], bd_a[k], pd_a[k]}, 5'b10000);
        repeat (3) @(posedge clk);
        #2 RESET = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (bd_a != 2'b00 || pd_a != 2'b00 || txd_a != 2'b11) bad++;
        end
        chk("no_stale_frame", 0, bad, 0);
        send(24'hFF00FF, 1'b0, n0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
